// File: rtl/subservient_wb_loader_if.sv
// Bus bundle for the subservient loader: management Wishbone slave
// side plus the subservient SRAM debug port.
interface subservient_wb_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dbg_stb_o;
  logic        dbg_we_o;
  logic [31:0] dbg_adr_o;
  logic [31:0] dbg_dat_o;
  logic [3:0]  dbg_sel_o;
  logic [31:0] dbg_dat_i;
  logic        dbg_ack_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output dbg_stb_o, dbg_we_o, dbg_adr_o,
    output dbg_dat_o, dbg_sel_o,
    input  dbg_dat_i, dbg_ack_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  dbg_stb_o, dbg_we_o, dbg_adr_o,
    input  dbg_dat_o, dbg_sel_o,
    output dbg_dat_i, dbg_ack_i
  );
endinterface

// File: rtl/subservient_wb_loader.sv
// Wishbone register window that loads/reads subservient SRAM
// through its debug port and holds the core in reset meanwhile.
module subservient_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  subservient_wb_loader_if.slave bus,
  output logic core_rst_o,
  output logic dbg_mode_o
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        block_q, block_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] dadr_q, dadr_d;
  logic [31:0] ddat_q, ddat_d;
  logic [3:0]  dsel_q, dsel_d;

  logic req, hit;
  logic sel_ctrl, sel_addr, sel_data, sel_stat;
  logic busy;
  logic unused;

  assign req = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign hit = req &&
    (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);

  assign sel_ctrl = hit && (bus.wbs_adr_i[3:2] == 2'd0);
  assign sel_addr = hit && (bus.wbs_adr_i[3:2] == 2'd1);
  assign sel_data = hit && (bus.wbs_adr_i[3:2] == 2'd2);
  assign sel_stat = hit && (bus.wbs_adr_i[3:2] == 2'd3);

  assign busy   = (state_q != IDLE);
  assign unused = ^bus.wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ctrl_q   <= 2'b11;
      addr_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      dadr_q   <= '0;
      ddat_q   <= '0;
      dsel_q   <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      dadr_q   <= dadr_d;
      ddat_q   <= ddat_d;
      dsel_q   <= dsel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    addr_d   = addr_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    block_d  = 1'b0;
    ack_d    = 1'b0;
    rdat_d   = '0;
    stb_d    = stb_q;
    we_d     = we_q;
    dadr_d   = dadr_q;
    ddat_d   = ddat_q;
    dsel_d   = dsel_q;

    unique case (state_q)
      IDLE: begin
        // block_q skips the cycle after an ack so a held stb
        // is not answered twice
        if (req && !block_q) begin
          state_d = RESP;
          ack_d   = 1'b1;
          unique case (1'b1)
            sel_ctrl: begin
              if (bus.wbs_we_i) ctrl_d = bus.wbs_dat_i[1:0];
              else rdat_d = {30'b0, ctrl_q};
            end
            sel_addr: begin
              if (bus.wbs_we_i)
                addr_d = {bus.wbs_dat_i[31:2], 2'b00};
              else rdat_d = addr_q;
            end
            sel_data: begin
              if (ctrl_q[1]) begin
                state_d = MEM;
                ack_d   = 1'b0;
                cnt_d   = '0;
                stb_d   = 1'b1;
                we_d    = bus.wbs_we_i;
                dadr_d  = addr_q;
                ddat_d  = bus.wbs_dat_i;
                dsel_d  = bus.wbs_sel_i;
              end
            end
            sel_stat: begin
              if (bus.wbs_we_i) begin
                if (bus.wbs_dat_i[1]) sticky_d = 1'b0;
              end else begin
                rdat_d = {30'b0, sticky_q, busy};
              end
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.dbg_ack_i) begin
          state_d = RESP;
          ack_d   = 1'b1;
          stb_d   = 1'b0;
          addr_d  = addr_q + 32'd4;
          rdat_d  = we_q ? 32'h0 : bus.dbg_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          ack_d    = 1'b1;
          stb_d    = 1'b0;
          sticky_d = 1'b1;
          rdat_d   = 32'hDEAD_BEEF;
        end
      end
      RESP: begin
        state_d = IDLE;
        block_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign bus.dbg_stb_o = stb_q;
  assign bus.dbg_we_o  = we_q;
  assign bus.dbg_adr_o = dadr_q;
  assign bus.dbg_dat_o = ddat_q;
  assign bus.dbg_sel_o = dsel_q;
  assign core_rst_o    = ctrl_q[0];
  assign dbg_mode_o    = ctrl_q[1];

endmodule

// File: tb/tb_subservient_wb_loader.sv
// Bench for subservient_wb_loader: directed and random bus traffic
// against a transaction-level model of the register window and SRAM.
module tb_subservient_wb_loader;
  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, dbg_mode;

  always #5 clk = ~clk;

  subservient_wb_loader_if bus();

  subservient_wb_loader #(
    .BASE_ADDR(BASE),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .core_rst_o(core_rst),
    .dbg_mode_o(dbg_mode)
  );

  int total = 0;
  int bad = 0;

  // SRAM responder state
  int mem_delay = 2;
  int wcnt = 0;
  int stb_cyc = 0;
  int acc_cnt = 0;
  logic spur = 1'b0;
  logic [31:0] last_adr = '0;
  logic last_we = 1'b0;
  logic [31:0] mem_store [logic [31:0]];

  // reference model
  logic [1:0]  m_ctrl;
  logic [31:0] m_addr;
  logic        m_sticky;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.dbg_ack_i = 1'b0;
    bus.dbg_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.dbg_ack_i = 1'b0;
      bus.dbg_dat_i = '0;
      if (bus.dbg_stb_o) begin
        stb_cyc++;
        if (mem_delay >= 0 && wcnt == mem_delay) begin
          logic [31:0] a, cur;
          a = bus.dbg_adr_o;
          cur = mem_store.exists(a) ? mem_store[a] : init_val(a);
          bus.dbg_ack_i = 1'b1;
          wcnt = 0;
          acc_cnt++;
          last_adr = a;
          last_we = bus.dbg_we_o;
          if (bus.dbg_we_o) begin
            for (int b = 0; b < 4; b++)
              if (bus.dbg_sel_o[b]) cur[b*8 +: 8] = bus.dbg_dat_o[b*8 +: 8];
            mem_store[a] = cur;
          end else begin
            bus.dbg_dat_i = cur;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.dbg_ack_i = spur;
        bus.dbg_dat_i = spur ? 32'hBAD0_BAD0 : 32'h0;
      end
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    lat = 0;
    rd = '0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        lat = i;
        rd = bus.wbs_dat_o;
        break;
      end
    end
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge clk);
    if (lat == 0) chk("ack_wait", 32'd0, 32'd1);
  endtask

  task automatic model_reset();
    m_ctrl = 2'b11;
    m_addr = '0;
    m_sticky = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int dly);
    logic [31:0] rd, exp_rd, exp_adr, cur;
    int lat, exp_lat, exp_stb, exp_acc, acc0, stb0;
    mem_delay = dly;
    exp_rd = '0;
    exp_lat = 1;
    exp_stb = 0;
    exp_acc = 0;
    exp_adr = '0;
    if (adr[31:4] == BASE[31:4]) begin
      case (adr[3:2])
        2'd0: if (we) m_ctrl = dat[1:0]; else exp_rd = {30'b0, m_ctrl};
        2'd1: if (we) m_addr = dat & ~32'h3; else exp_rd = m_addr;
        2'd2: if (m_ctrl[1]) begin
          exp_adr = m_addr;
          if (dly >= 0 && dly <= TO - 1) begin
            exp_lat = dly + 2;
            exp_stb = dly + 1;
            exp_acc = 1;
            cur = ref_mem.exists(m_addr) ? ref_mem[m_addr]
                                         : init_val(m_addr);
            if (we) begin
              for (int b = 0; b < 4; b++)
                if (sel[b]) cur[b*8 +: 8] = dat[b*8 +: 8];
              ref_mem[m_addr] = cur;
            end else begin
              exp_rd = cur;
            end
            m_addr = m_addr + 32'd4;
          end else begin
            exp_lat = TO + 1;
            exp_stb = TO;
            exp_rd = 32'hDEAD_BEEF;
            m_sticky = 1'b1;
          end
        end
        default: if (we) begin
          if (dat[1]) m_sticky = 1'b0;
        end else begin
          exp_rd = {30'b0, m_sticky, 1'b0};
        end
      endcase
    end
    acc0 = acc_cnt;
    stb0 = stb_cyc;
    xfer(we, adr, dat, sel, rd, lat);
    if (!we) chk({tag, ":rdata"}, rd, exp_rd);
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":stbcyc"}, 32'(stb_cyc - stb0), 32'(exp_stb));
    chk({tag, ":acc"}, 32'(acc_cnt - acc0), 32'(exp_acc));
    if (exp_acc != 0) begin
      chk({tag, ":dbgadr"}, last_adr, exp_adr);
      chk({tag, ":dbgwe"}, {31'b0, last_we}, {31'b0, we});
    end
    chk({tag, ":pins"}, {30'b0, dbg_mode, core_rst}, {30'b0, m_ctrl});
  endtask

  initial begin
    logic [31:0] a, d;
    int k, dly;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    chk("rst:dat", bus.wbs_dat_o, 32'd0);
    chk("rst:stb", {31'b0, bus.dbg_stb_o}, 32'd0);
    chk("rst:adr", bus.dbg_adr_o, 32'd0);
    chk("rst:pins", {30'b0, dbg_mode, core_rst}, 32'd3);
    @(negedge clk);
    rst = 1'b0;

    do_op("ctrl_rd", 1'b0, BASE, 0, 4'hF, 0);
    do_op("addr_wr", 1'b1, BASE + 4, 32'h100, 4'hF, 0);
    do_op("load0", 1'b1, BASE + 8, 32'h1111_1111, 4'hF, 2);
    do_op("load1", 1'b1, BASE + 8, 32'h2222_2222, 4'hF, 2);
    do_op("addr_rd", 1'b0, BASE + 4, 0, 4'hF, 0);
    do_op("addr_wr2", 1'b1, BASE + 4, 32'h103, 4'hF, 0);
    do_op("mem_rd", 1'b0, BASE + 8, 0, 4'hF, 2);
    do_op("addr_rd2", 1'b0, BASE + 4, 0, 4'hF, 0);

    do_op("tmo_rd", 1'b0, BASE + 8, 0, 4'hF, -1);
    do_op("stat_rd", 1'b0, BASE + 12, 0, 4'hF, 0);
    do_op("stat_w0", 1'b1, BASE + 12, 32'h0, 4'hF, 0);
    do_op("stat_rd1", 1'b0, BASE + 12, 0, 4'hF, 0);
    do_op("stat_clr", 1'b1, BASE + 12, 32'h2, 4'hF, 0);
    do_op("stat_rd2", 1'b0, BASE + 12, 0, 4'hF, 0);
    do_op("edge_ok", 1'b0, BASE + 8, 0, 4'hF, TO - 1);
    do_op("edge_tmo", 1'b0, BASE + 8, 0, 4'hF, TO);
    do_op("stat_rd3", 1'b0, BASE + 12, 0, 4'hF, 0);
    do_op("stat_clr2", 1'b1, BASE + 12, 32'hFFFF_FFFF, 4'hF, 0);

    do_op("wrap_wr", 1'b1, BASE + 4, 32'hFFFF_FFFC, 4'hF, 0);
    do_op("wrap_acc", 1'b0, BASE + 8, 0, 4'hF, 0);
    do_op("wrap_rd", 1'b0, BASE + 4, 0, 4'hF, 0);

    spur = 1'b1;
    repeat (4) @(negedge clk);
    do_op("spur_rd", 1'b0, BASE + 4, 0, 4'hF, 0);
    spur = 1'b0;

    do_op("unmap_rd", 1'b0, BASE + 32'h40, 0, 4'hF, 0);
    do_op("unmap_wr", 1'b1, BASE + 32'h40, 32'h3, 4'hF, 0);
    do_op("unmap_ck", 1'b0, BASE, 0, 4'hF, 0);

    // stb held past the ack must not be answered again
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE;
    @(posedge clk);
    #1;
    chk("hold:ack1", {31'b0, bus.wbs_ack_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("hold:ack2", {31'b0, bus.wbs_ack_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold:ack3", {31'b0, bus.wbs_ack_o}, 32'd0);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      dly = $urandom_range(0, TO);
      case (k)
        0: begin
          if ($urandom_range(0, 4) != 0) d[1] = 1'b1;
          do_op("r_ctrl_wr", 1'b1, BASE, d, 4'hF, 0);
        end
        1: do_op("r_addr_wr", 1'b1, BASE + 4, d, 4'hF, 0);
        2, 3: do_op("r_mem_wr", 1'b1, BASE + 8, d,
                    4'($urandom_range(0, 15)), dly);
        4: do_op("r_mem_rd", 1'b0, BASE + 8, 0, 4'hF, dly);
        5: do_op("r_stat_rd", 1'b0, BASE + 12, 0, 4'hF, 0);
        6: do_op("r_ctrl_rd", 1'b0, BASE, 0, 4'hF, 0);
        7: do_op("r_addr_rd", 1'b0, BASE + 4, 0, 4'hF, 0);
        8: begin
          a = $urandom;
          if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
          do_op("r_unmap", d[0], a, d, 4'hF, 0);
        end
        default: do_op("r_stat_wr", 1'b1, BASE + 12, d, 4'hF, 0);
      endcase
    end

    do_op("rel_ctrl", 1'b1, BASE, 32'h0, 4'hF, 0);
    do_op("rel_data", 1'b0, BASE + 8, 0, 4'hF, 0);
    do_op("mode_on", 1'b1, BASE, 32'h3, 4'hF, 0);

    // reset in the middle of a memory access
    mem_delay = -1;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE + 8;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst:stb_pre", {31'b0, bus.dbg_stb_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst:stb", {31'b0, bus.dbg_stb_o}, 32'd0);
    chk("mrst:ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mrst:ack2", {31'b0, bus.wbs_ack_o}, 32'd0);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    rst = 1'b0;
    model_reset();
    do_op("mrst_ctrl", 1'b0, BASE, 0, 4'hF, 0);
    do_op("mrst_addr", 1'b0, BASE + 4, 0, 4'hF, 0);
    do_op("mrst_stat", 1'b0, BASE + 12, 0, 4'hF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/subservient_wb_loader.md
SUBSERVIENT_WB_LOADER -- requirements
Module: subservient_wb_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: base address of the 16-byte register window.
REQ-002 Parameter TIMEOUT, default 255: number of cycles to wait for dbg_ack_i before abandoning a memory access; legal range 1..255.
REQ-003 wb_clk_i  in  1: single clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1: synchronous, active-high reset.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each: management Wishbone slave request.
REQ-006 wbs_sel_i  in  4: byte selects; forwarded on memory writes, ignored for register writes.
REQ-007 wbs_adr_i, wbs_dat_i  in  32 each: byte address and write data.
REQ-008 wbs_ack_o  out  1: single-cycle acknowledge.
REQ-009 wbs_dat_o  out  32: read data, valid only while wbs_ack_o=1, otherwise 0.
REQ-010 dbg_stb_o, dbg_we_o  out  1 each: strobe and write-enable to the subservient memory debug port.
REQ-011 dbg_adr_o  out  32: debug byte address, bits[1:0] always 0.
REQ-012 dbg_dat_o  out  32 and dbg_sel_o  out  4: debug write data and byte selects.
REQ-013 dbg_dat_i  in  32 and dbg_ack_i  in  1: debug read data and single-cycle acknowledge.
REQ-014 core_rst_o  out  1: holds the subservient core in reset while 1.
REQ-015 dbg_mode_o  out  1: selects the debug port as SRAM owner while 1.

Function
REQ-016 Hit condition: cyc&stb and wbs_adr_i[31:4]==BASE_ADDR[31:4]; offset is wbs_adr_i[3:2].
REQ-017 Registers: 0=CTRL, 1=ADDR, 2=DATA, 3=STATUS.
REQ-018 CTRL: bit0 drives core_rst_o and bit1 drives dbg_mode_o; both are read/write; other bits read 0.
REQ-019 ADDR: 32-bit read/write; bits[1:0] are forced to 0 on write.
REQ-020 STATUS (read-only except bit1): bit0=busy (FSM not IDLE), bit1=timeout sticky, which writing 1 clears and writing 0 leaves unchanged; other bits read 0.
REQ-021 The FSM has states IDLE, MEM, RESP.
REQ-022 IDLE: a hit on CTRL, ADDR or STATUS, or a non-hit cyc&stb, goes to RESP with the write applied in that cycle.
REQ-023 Non-hit requests read 0 and have no side effects, so the bus never hangs.
REQ-024 IDLE: a DATA hit with dbg_mode_o=1 goes to MEM, asserting dbg_stb_o=1, dbg_adr_o=ADDR, dbg_we_o=wbs_we_i, dbg_dat_o=wbs_dat_i and dbg_sel_o=wbs_sel_i, all held stable in MEM.
REQ-025 IDLE: a DATA hit with dbg_mode_o=0 goes to RESP without a memory access; it reads 0 and sets no error.
REQ-026 MEM: when dbg_ack_i=1, drop dbg_stb_o, capture dbg_dat_i for reads, set ADDR<=ADDR+4 (wraps modulo 2^32), and go to RESP.
REQ-027 MEM: if TIMEOUT cycles elapse without dbg_ack_i, drop dbg_stb_o, set the timeout sticky bit, load read data 32'hDEAD_BEEF, leave ADDR unchanged, and go to RESP.
REQ-028 Timeout counter: 8 bits, cleared on MEM entry, incremented each cycle in MEM.
REQ-029 dbg_ack_i arriving on the same cycle the counter reaches TIMEOUT counts as success.
REQ-030 RESP: assert wbs_ack_o=1 for exactly one cycle with the captured wbs_dat_o, then return to IDLE.
REQ-031 In the IDLE cycle that follows RESP, a new request is not accepted, which prevents a double ack on a held stb.
REQ-032 If cyc drops during MEM, the memory access still completes; the RESP ack is still pulsed once and is ignored by the master.
REQ-033 dbg_ack_i outside MEM is ignored.
REQ-034 Latency: register access is ack'd 1 cycle after request sampling; memory access is ack'd 1 cycle after dbg_ack_i.

Reset
REQ-035 On wb_rst_i=1 at a clock edge, all of the following take these values, regardless of state, including mid-MEM:
- CTRL=2'b11, so core_rst_o=1 and dbg_mode_o=1.
- ADDR=0 and the timeout sticky bit=0.
- FSM=IDLE and the timeout counter=0.
- wbs_ack_o=0, wbs_dat_o=0, dbg_stb_o=0, dbg_we_o=0, dbg_adr_o=0, dbg_dat_o=0, dbg_sel_o=0.
REQ-036 A request present while wb_rst_i=1 is dropped without ack.

Verification
REQ-037 After reset, read CTRL at 0x3000_0000 -> ack on the next cycle, data 0x3; core_rst_o=1; dbg_mode_o=1.
REQ-038 Load program: write ADDR=0x100, then write DATA 0x1111_1111 and 0x2222_2222 (memory model acks after 3 cycles) -> debug writes at 0x100 and 0x104; ADDR reads back 0x108.
REQ-039 Read back memory: with ADDR=0x100, read DATA -> wbs_dat_o=0x1111_1111; ADDR becomes 0x104.
REQ-040 Timeout: the memory model never acks; read DATA -> ack after TIMEOUT+1 cycles with 0xDEAD_BEEF; STATUS reads 0x2; write STATUS 0x2 -> STATUS reads 0.
REQ-041 Release the core: write CTRL=0 -> core_rst_o=0 and dbg_mode_o=0; a subsequent DATA read returns 0 with no dbg_stb_o.
REQ-042 Unmapped address 0x3000_0040 -> ack with 0 and no state change.
REQ-043 wb_rst_i asserted during MEM -> dbg_stb_o=0 on the next cycle, no ack, CTRL=0x3.
REQ-044 With ADDR=0xFFFF_FFFC, a successful access -> ADDR=0.
